txepreambl_insert: RTL and testbench

- Transmit-side counterpart of the receive preamble stripper.
- Accepts a raw Ethernet frame byte stream (destination MAC first) from the TX framing logic, and emits NPRE bytes of 8'h55 followed by the SFD byte 8'h5d.
  - 8'h5d is the codebase's nibble order, as expected by the receive stripper.
  - The frame bytes follow, delayed through an internal delay line.
- Sits between the TX CRC/framing stage and the byte-to-nibble PHY serializer.

---
 rtl/eth_pkg.sv | 18 +
 rtl/eth_byte_delay.sv | 35 +++
 rtl/txepreambl_insert.sv | 116 +++++++++++
 tb/tb_txepreambl_insert.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet TX/RX constants and types: preamble/SFD bytes, TX state encoding,
// and the {valid, byte} stage carried by byte delay lines.
package eth_pkg;
    localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] ETH_SFD_BYTE      = 8'h5d;  // nibble order expected by the RX stripper

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        BYPASS   = 2'd3
    } tx_state_t;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } byte_stage_t;
endpackage

// File: rtl/eth_byte_delay.sv
// Depth-N {valid, byte} shift register with synchronous clear; o_any flags any valid stage.
module eth_byte_delay
    import eth_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic        i_shift,
    input  byte_stage_t i_stage,
    output byte_stage_t o_stage,
    output logic        o_any
);
    byte_stage_t [DEPTH-1:0] stages;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            stages <= '0;
        end else if (i_shift) begin
            stages[0] <= i_stage;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    always_comb begin
        o_any = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            o_any = o_any | stages[i].v;
        end
    end

    assign o_stage = stages[DEPTH-1];
endmodule

// File: rtl/txepreambl_insert.sv
// TX preamble inserter: prepends NPRE x 8'h55 and the SFD to each frame, delaying the
// frame bytes through an NPRE+1 stage line; i_en=0 passes frames through with latency 1.
module txepreambl_insert
    import eth_pkg::*;
#(
    parameter int NPRE = 7
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic       i_v,
    input  logic [7:0] i_d,
    output logic       o_v,
    output logic [7:0] o_d,
    output logic       o_drop
);
    localparam logic [3:0] NPRE_C = 4'(NPRE);

    tx_state_t   state, state_nxt;
    logic [3:0]  cnt, cnt_nxt, cnt_inc;
    logic        in_done, in_done_nxt;
    logic        v_q, start;
    logic        o_v_nxt, o_drop_nxt;
    logic [7:0]  o_d_nxt;
    logic        dl_shift, dl_any;
    byte_stage_t dl_in, dl_out;

    eth_byte_delay #(.DEPTH(NPRE + 1)) u_delay (
        .i_clk   (i_clk),
        .i_clr   (i_reset),
        .i_shift (dl_shift),
        .i_stage (dl_in),
        .o_stage (dl_out),
        .o_any   (dl_any)
    );

    // A start needs a rising i_v, so a frame cut by reset is ignored until i_v drops.
    assign start   = i_v && !v_q;
    assign cnt_inc = cnt + 4'd1;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        in_done_nxt = in_done;
        o_v_nxt     = 1'b0;
        o_d_nxt     = 8'h00;
        o_drop_nxt  = 1'b0;
        dl_shift    = 1'b0;
        dl_in.v     = i_v && !in_done;
        dl_in.d     = i_d;
        case (state)
            IDLE: begin
                if (start && i_en) begin
                    state_nxt   = PREAMBLE;
                    cnt_nxt     = 4'd0;
                    in_done_nxt = 1'b0;
                    dl_shift    = 1'b1;
                    dl_in.v     = 1'b1;
                    o_v_nxt     = 1'b1;
                    o_d_nxt     = ETH_PREAMBLE_BYTE;
                end else if (start) begin
                    state_nxt = BYPASS;
                    o_v_nxt   = 1'b1;
                    o_d_nxt   = i_d;
                end
            end
            PREAMBLE: begin
                dl_shift = 1'b1;
                o_v_nxt  = 1'b1;
                cnt_nxt  = cnt_inc;
                if (cnt_inc == NPRE_C) begin
                    o_d_nxt   = ETH_SFD_BYTE;
                    state_nxt = DATA;
                end else begin
                    o_d_nxt = ETH_PREAMBLE_BYTE;
                end
            end
            DATA: begin
                dl_shift = 1'b1;
                o_v_nxt  = dl_out.v;
                o_d_nxt  = dl_out.v ? dl_out.d : 8'h00;
                if (!dl_any && !i_v) state_nxt = IDLE;
            end
            BYPASS: begin
                o_v_nxt = i_v;
                o_d_nxt = i_v ? i_d : 8'h00;
                if (!i_v) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A frame arriving while the previous one is still draining is discarded whole.
        if (state == PREAMBLE || state == DATA) begin
            if (!i_v) in_done_nxt = 1'b1;
            if (in_done && start) o_drop_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        v_q <= i_v;
        if (i_reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            in_done <= 1'b0;
            o_v     <= 1'b0;
            o_d     <= 8'h00;
            o_drop  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            in_done <= in_done_nxt;
            o_v     <= o_v_nxt;
            o_d     <= o_d_nxt;
            o_drop  <= o_drop_nxt;
        end
    end
endmodule

// File: tb/tb_txepreambl_insert.sv
// Scoreboard bench: stimulus predicts (cycle, byte) outputs and drop pulses per frame;
// a negedge monitor pops and compares whatever the DUT presents.
module tb_txepreambl_insert;
    localparam int NPRE = 7;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_en = 1'b0;
    logic       i_v = 1'b0;
    logic [7:0] i_d = 8'h00;
    logic       o_v;
    logic [7:0] o_d;
    logic       o_drop;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    int         drop_q[$];
    logic [7:0] fbuf[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    int         ready_cyc = 0;

    txepreambl_insert #(.NPRE(NPRE)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (i_en),
        .i_v     (i_v),
        .i_d     (i_d),
        .o_v     (o_v),
        .o_d     (o_d),
        .o_drop  (o_drop)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic exp_t mk(int c, logic [7:0] d);
        exp_t e;
        e.cyc = c;
        e.d   = d;
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
    endtask

    // Monitor
    always @(negedge i_clk) begin
        if (cyc >= 1) begin
            if (o_v === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_o_v", 32'(o_d), 32'hffff_ffff);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_cycle", cyc, mon_e.cyc);
                    check("out_byte", 32'(o_d), 32'(mon_e.d));
                end
            end else begin
                check("idle_o_v_o_d", {23'd0, o_v, o_d}, 32'd0);
                if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                    mon_e = exp_q.pop_front();
                    check("missing_byte_cycle", cyc + 1, mon_e.cyc);
                end
            end
            if (o_drop === 1'b1) begin
                if (drop_q.size() == 0) check("unexpected_drop", cyc, 32'hffff_ffff);
                else check("drop_cycle", cyc, drop_q.pop_front());
            end else begin
                check("o_drop_known", 32'(o_drop), 32'd0);
                if (drop_q.size() != 0 && drop_q[0] <= cyc) check("missing_drop", cyc + 1, drop_q.pop_front());
            end
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge i_clk); #1;
            i_reset = 1'b0;
            i_v     = 1'b0;
            i_d     = 8'($urandom);
            i_en    = 1'($urandom);
        end
    endtask

    task automatic fill_rand(int len);
        fbuf.delete();
        for (int j = 0; j < len; j++) fbuf.push_back(8'($urandom));
    endtask

    // Reference: frame starting at s is accepted iff s >= ready_cyc. Insert mode emits
    // NPRE preamble bytes, SFD, then data from s+1; bypass emits data from s+1.
    task automatic send(bit en, int rst_at);
        int s;
        int len;
        len = fbuf.size();
        s   = 0;
        for (int k = 0; k < len; k++) begin
            @(posedge i_clk); #1;
            i_v     = 1'b1;
            i_d     = fbuf[k];
            i_en    = (k == 0) ? en : 1'($urandom);
            i_reset = (k == rst_at);
            if (k == 0) begin
                s = cyc;
                if (s >= ready_cyc) begin
                    if (en) begin
                        for (int j = 0; j < NPRE; j++) exp_q.push_back(mk(s + 1 + j, 8'h55));
                        exp_q.push_back(mk(s + 1 + NPRE, 8'h5d));
                        for (int j = 0; j < len; j++) exp_q.push_back(mk(s + NPRE + 2 + j, fbuf[j]));
                        ready_cyc = s + len + NPRE + 2;
                    end else begin
                        for (int j = 0; j < len; j++) exp_q.push_back(mk(s + 1 + j, fbuf[j]));
                        ready_cyc = s + len + 1;
                    end
                end else begin
                    drop_q.push_back(s + 1);
                    if (s + len + 1 > ready_cyc) ready_cyc = s + len + 1;
                end
            end
            if (k == rst_at) begin
                while (exp_q.size() != 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
                while (drop_q.size() != 0 && drop_q[$] > cyc) void'(drop_q.pop_back());
                ready_cyc = s + len + 1;
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        idle(4);

        // 4-byte insert frame, then a bypass frame after exactly NPRE+2 idle cycles
        fbuf.delete();
        fbuf.push_back(8'hA1); fbuf.push_back(8'hB2); fbuf.push_back(8'hC3); fbuf.push_back(8'hD4);
        send(1'b1, -1);
        idle(NPRE + 2);
        fbuf.delete();
        fbuf.push_back(8'h11); fbuf.push_back(8'h22);
        send(1'b0, -1);
        idle(NPRE + 4);

        // 1-byte frame, then an early frame 3 cycles later that must be dropped
        fbuf.delete();
        fbuf.push_back(8'h77);
        send(1'b1, -1);
        idle(3);
        fbuf.delete();
        fbuf.push_back(8'h99); fbuf.push_back(8'h88);
        send(1'b1, -1);
        idle(NPRE + 4);

        // Reset at t0+5 of a 20-byte frame, then a clean frame
        fill_rand(20);
        send(1'b1, 5);
        idle(NPRE + 4);
        fill_rand(6);
        send(1'b1, -1);
        idle(NPRE + 2);

        // 64 random bytes, then back-to-back insert frames
        fill_rand(64);
        send(1'b1, -1);
        idle(NPRE + 2);
        fill_rand(5);
        send(1'b1, -1);
        idle(NPRE + 2);

        repeat (40) begin
            fill_rand(int'($urandom_range(1, 24)));
            send(1'($urandom), -1);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, NPRE + 1)));
            else idle(NPRE + 2 + int'($urandom_range(0, 4)));
        end

        idle(3 * NPRE + 10);
        check("exp_q_drained", exp_q.size(), 0);
        check("drop_q_drained", drop_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
